// File: rtl/mc_mem_interface.sv
// mc_mem_interface
// Bridges the multicycle controller's per-state memory controls onto a
// single unified instruction/data memory with a request/ready handshake.
// The controller is stalled for as long as the memory takes. The access
// always finishes with one DONE cycle in which the controller advances.
module mc_mem_interface #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              iord,
  input  logic              irwrite,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [DATA_W-1:0] writedata,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // The counter has enough width to hold TIMEOUT-1 for any TIMEOUT >= 1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                to_ir_reg;     // read result goes to instr (else mdr)
  logic                err_reg;
  logic                mem_req_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [DATA_W-1:0]   instr_reg;
  logic [DATA_W-1:0]   mdr_reg;

  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W-1:0]   aligned_addr;
  logic                misaligned;

  // Address source selected by the controller: pc for fetch, aluout for data.
  assign sel_addr   = iord ? aluout : pc;
  assign misaligned = |sel_addr[1:0];

  // The memory is word-addressed: the two byte-offset bits are always zero.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_align
      if (gi < 2) begin : g_low
        assign aligned_addr[gi] = 1'b0;
      end else begin : g_high
        assign aligned_addr[gi] = sel_addr[gi];
      end
    end
  endgenerate

  // Stall is combinational in IDLE so the controller holds on the very
  // cycle it first asks for memory; BUSY always stalls, DONE never does.
  always_comb begin
    stall = 1'b0;
    case (state_reg)
      IDLE:    stall = req_valid;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Access sequencer: capture on request, wait for ready or timeout, then
  // spend one DONE cycle before accepting the next request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      to_ir_reg     <= 1'b0;
      err_reg       <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      instr_reg     <= '0;
      mdr_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            mem_addr_reg  <= aligned_addr;
            mem_wdata_reg <= writedata;
            mem_we_reg    <= memwrite;
            // A write never targets the instruction register, even if the
            // controller (illegally) raises irwrite alongside memwrite.
            to_ir_reg     <= irwrite & ~memwrite;
            cnt_reg       <= '0;
            mem_req_reg   <= 1'b1;
            state_reg     <= BUSY;
            if (misaligned) begin
              err_reg <= 1'b1;
            end
          end
        end

        BUSY: begin
          if (mem_ready) begin
            if (!mem_we_reg) begin
              if (to_ir_reg) begin
                instr_reg <= mem_rdata;
              end else begin
                mdr_reg <= mem_rdata;
              end
            end
            mem_req_reg <= 1'b0;
            state_reg   <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            // Give up on an unresponsive memory; destination regs untouched.
            err_reg     <= 1'b1;
            mem_req_reg <= 1'b0;
            state_reg   <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign instr     = instr_reg;
  assign mdr       = mdr_reg;
  assign err       = err_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule
